multicycle_ctrl: RTL and testbench

- Multi-cycle RISC-V control unit: next generation of the single-cycle main decoder.
- Sequences each instruction through an FSM sharing one ALU and one unified memory port.
- Parametrised memory latency: memory states are held for MEM_LAT cycles.
- Detects illegal opcodes and parks in a TRAP state; issues a one-cycle retire pulse per completed instruction.

---
 rtl/ctrl_pkg.sv | 47 ++++
 rtl/imm_src_dec.sv | 20 ++
 rtl/multicycle_ctrl.sv | 161 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and mux encodings for the multi-cycle control unit
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/imm_src_dec.sv
// rtl/imm_src_dec.sv - immediate format select, decoded from the opcode alone
module imm_src_dec
  import ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [2:0] o_immsrc
);

  always_comb begin
    o_immsrc = IMM_I;
    case (i_op)
      OP_LW, OP_I: o_immsrc = IMM_I;
      OP_SW:       o_immsrc = IMM_S;
      OP_BEQ:      o_immsrc = IMM_B;
      OP_JAL:      o_immsrc = IMM_J;
      default:     o_immsrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RISC-V control FSM with a shared ALU and one memory port
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic [2:0] immsrc,
  output logic       retire,
  output logic       illegal
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;
  logic             w_mem;

  logic w_pcwrite, w_memwrite, w_irwrite, w_regwrite, w_retire;

  assign w_last = (r_cnt == LAST_CNT);
  assign w_mem  = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (w_last) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (w_last) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (w_last) w_next = S_FETCH;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Wait counter restarts on every transition so each memory state starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || !w_mem) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_retire   = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RS2;
    aluop      = ALUOP_ADD;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        w_irwrite = w_last;
        w_pcwrite = w_last;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: adrsrc = 1'b1;
      S_MEMWB: begin
        resultsrc  = RES_DATA;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        w_memwrite = w_last;
        w_retire   = w_last;
      end
      S_EXECUTER: begin
        alusrca = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alusrca = SRCA_RS1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BEQ: begin
        alusrca   = SRCA_RS1;
        aluop     = ALUOP_SUB;
        w_pcwrite = zero;
        w_retire  = 1'b1;
      end
      S_JAL: begin
        alusrca   = SRCA_OLDPC;
        alusrcb   = SRCB_FOUR;
        w_pcwrite = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  // Enables are masked combinationally so nothing is written while reset is held.
  assign pcwrite  = w_pcwrite  & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign irwrite  = w_irwrite  & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign retire   = w_retire   & ~reset;

  imm_src_dec u_imm_src_dec (
    .i_op     (op),
    .o_immsrc (immsrc)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed bench for multicycle_ctrl at MEM_LAT 1, 2 and 3
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = OP_R;
  logic       zero = 1'b0;

  logic [2:0]      pcwrite_v, adrsrc_v, memwrite_v, irwrite_v, regwrite_v, retire_v, illegal_v;
  logic [2:0][1:0] resultsrc_v, alusrca_v, alusrcb_v, aluop_v;
  logic [2:0][2:0] immsrc_v;

  int n_assert = 0;
  int n_fail   = 0;
  int n_ret;
  int n_rw;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    multicycle_ctrl #(.MEM_LAT(g + 1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .zero      (zero),
      .pcwrite   (pcwrite_v[g]),
      .adrsrc    (adrsrc_v[g]),
      .memwrite  (memwrite_v[g]),
      .irwrite   (irwrite_v[g]),
      .resultsrc (resultsrc_v[g]),
      .alusrca   (alusrca_v[g]),
      .alusrcb   (alusrcb_v[g]),
      .aluop     (aluop_v[g]),
      .regwrite  (regwrite_v[g]),
      .immsrc    (immsrc_v[g]),
      .retire    (retire_v[g]),
      .illegal   (illegal_v[g])
    );
  end

  // {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, aluop, regwrite, immsrc, retire, illegal}
  function automatic logic [17:0] ov(logic pcw, logic adr, logic mw, logic irw, logic [1:0] res,
                                     logic [1:0] sa, logic [1:0] sb, logic [1:0] aop, logic rw,
                                     logic [2:0] imm, logic ret, logic ill);
    return {pcw, adr, mw, irw, res, sa, sb, aop, rw, imm, ret, ill};
  endfunction

  function automatic logic [17:0] obs(int k);
    return {pcwrite_v[k], adrsrc_v[k], memwrite_v[k], irwrite_v[k], resultsrc_v[k], alusrca_v[k],
            alusrcb_v[k], aluop_v[k], regwrite_v[k], immsrc_v[k], retire_v[k], illegal_v[k]};
  endfunction

  function automatic logic [17:0] f_wait(logic [2:0] imm);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] f_last(logic [2:0] imm);
    return ov(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] f_dec(logic [2:0] imm);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, imm, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] f_madr(logic [2:0] imm);
    return ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, imm, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, o, e);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic rst_release(input logic [6:0] o);
    reset = 1'b1;
    op = o;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  logic [17:0] exp_lw [10];
  logic [17:0] exp_sw [7];
  logic [17:0] trap_v;

  initial begin
    trap_v = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, IMM_I, 1'b0, 1'b1);

    #7;
    chk("rst_state_lat1", obs(0), f_wait(IMM_I));
    chk("rst_state_lat3", obs(2), f_wait(IMM_I));

    // R-type at MEM_LAT=1; op is corrupted in EXECUTER and must be ignored
    rst_release(OP_R);
    chk("r_fetch", obs(0), f_last(IMM_I));
    step; chk("r_decode", obs(0), f_dec(IMM_I));
    step; chk("r_executer", obs(0), ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, IMM_I, 1'b0, 1'b0));
    op = 7'b1111111;
    step; chk("r_aluwb", obs(0), ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, IMM_I, 1'b1, 1'b0));
    step; chk("r_fetch_again", obs(0), f_last(IMM_I));

    // LW at MEM_LAT=3
    exp_lw[0] = f_wait(IMM_I);
    exp_lw[1] = f_wait(IMM_I);
    exp_lw[2] = f_last(IMM_I);
    exp_lw[3] = f_dec(IMM_I);
    exp_lw[4] = f_madr(IMM_I);
    exp_lw[5] = ov(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, IMM_I, 1'b0, 1'b0);
    exp_lw[6] = exp_lw[5];
    exp_lw[7] = exp_lw[5];
    exp_lw[8] = ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, IMM_I, 1'b1, 1'b0);
    exp_lw[9] = f_wait(IMM_I);
    rst_release(OP_LW);
    n_ret = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step;
      chk($sformatf("lw_cycle%0d", i + 1), obs(2), exp_lw[i]);
      if (i < 9 && retire_v[2]) n_ret++;
    end
    chk("lw_retire_count", 18'(n_ret), 18'd1);

    // SW at MEM_LAT=2
    exp_sw[0] = f_wait(IMM_S);
    exp_sw[1] = f_last(IMM_S);
    exp_sw[2] = f_dec(IMM_S);
    exp_sw[3] = f_madr(IMM_S);
    exp_sw[4] = ov(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, IMM_S, 1'b0, 1'b0);
    exp_sw[5] = ov(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, IMM_S, 1'b1, 1'b0);
    exp_sw[6] = f_wait(IMM_S);
    rst_release(OP_SW);
    n_rw = 0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step;
      chk($sformatf("sw_cycle%0d", i + 1), obs(1), exp_sw[i]);
      if (regwrite_v[1]) n_rw++;
    end
    chk("sw_regwrite_count", 18'(n_rw), 18'd0);

    // BEQ taken then not taken at MEM_LAT=1
    zero = 1'b1;
    rst_release(OP_BEQ);
    chk("beq_fetch", obs(0), f_last(IMM_B));
    step; chk("beq_decode", obs(0), f_dec(IMM_B));
    step; chk("beq_taken", obs(0), ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, IMM_B, 1'b1, 1'b0));
    zero = 1'b0;
    step; chk("beq2_fetch", obs(0), f_last(IMM_B));
    step; chk("beq2_decode", obs(0), f_dec(IMM_B));
    step; chk("beq_not_taken", obs(0), ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, IMM_B, 1'b1, 1'b0));

    // JAL at MEM_LAT=1
    rst_release(OP_JAL);
    chk("jal_fetch", obs(0), f_last(IMM_J));
    step; chk("jal_decode", obs(0), f_dec(IMM_J));
    step; chk("jal_jal", obs(0), ov(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, IMM_J, 1'b0, 1'b0));
    step; chk("jal_aluwb", obs(0), ov(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, IMM_J, 1'b1, 1'b0));
    step; chk("jal_fetch_again", obs(0), f_last(IMM_J));

    // Illegal opcode parks in TRAP until an asynchronous reset
    rst_release(7'b1111111);
    chk("ill_fetch", obs(0), f_last(IMM_I));
    step; chk("ill_decode", obs(0), f_dec(IMM_I));
    for (int i = 0; i < 20; i++) begin
      step; chk($sformatf("trap_hold%0d", i), obs(0), trap_v);
    end
    chk("trap_lat3", obs(2), trap_v);
    #2 reset = 1'b1;
    #1 chk("trap_async_rst", obs(0), f_wait(IMM_I));
    op = OP_LW;
    @(negedge clk);
    reset = 1'b0;
    #1 chk("post_trap_cnt0", obs(2), f_wait(IMM_I));
    step; chk("post_trap_cnt1", obs(2), f_wait(IMM_I));
    step; chk("post_trap_last", obs(2), f_last(IMM_I));
    step; chk("lw2_decode", obs(2), f_dec(IMM_I));
    step; chk("lw2_memadr", obs(2), f_madr(IMM_I));
    step;
    step; chk("lw2_memread", obs(2), exp_lw[5]);

    // Reset mid-MEMREAD: immediate return to FETCH with no write
    #2 reset = 1'b1;
    #1 chk("memread_async_rst", obs(2), f_wait(IMM_I));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst2_cnt0", obs(2), f_wait(IMM_I));
    step; chk("rst2_cnt1", obs(2), f_wait(IMM_I));
    step; chk("rst2_last", obs(2), f_last(IMM_I));
    step; chk("rst2_decode", obs(2), f_dec(IMM_I));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
